serial_msg_bridge: RTL

Parametrised native UART-to-message bridge. It replaces the soft-processor serial path with pure RTL.
- RX: deserialises 8N1 UART bytes and packs them little-endian into MSG_WIDTH-bit messages, delivered through a RDY/EN get interface.
- TX: accepts messages through a RDY/EN put interface and serialises them byte-by-byte onto the UART.
- Sits directly under the physical-platform serial device, facing the host link.

---
 rtl/serial_msg_pkg.sv | 22 ++
 rtl/serial_msg_fifo.sv | 54 +++++
 rtl/serial_msg_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_msg_pkg.sv
// Shared types and elaboration helpers for the UART-to-message bridge.
package serial_msg_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned bpm(input int unsigned w);
    return w / 8;
  endfunction

  function automatic bit width_ok(input int unsigned w);
    return (w % 8 == 0) && (w >= 8) && (w <= 256);
  endfunction

endpackage

// File: rtl/serial_msg_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted if a pop occurs in the same cycle.
module serial_msg_fifo
  import serial_msg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_msg_bridge.sv
// UART 8N1 <-> message bridge: RX bytes packed little-endian into messages, TX messages serialised byte-by-byte.
module serial_msg_bridge
  import serial_msg_pkg::*;
#(
  parameter int unsigned MSG_WIDTH    = 32,
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                 sys_clk_pin,
  input  logic                 sys_rst_pin,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  output logic                 RDY_msgOutput_get,
  output logic [MSG_WIDTH-1:0] msgOutput_get,
  input  logic                 EN_msgOutput_get,
  output logic                 RDY_msgInput_put,
  input  logic [MSG_WIDTH-1:0] msgInput_put,
  input  logic                 EN_msgInput_put,
  output logic                 rx_overflow,
  output logic                 rx_frame_err
);

  if (!width_ok(MSG_WIDTH)) begin : g_bad_width
    $error("serial_msg_bridge: MSG_WIDTH must be a multiple of 8 in 8..256");
  end

  localparam int unsigned BPM        = bpm(MSG_WIDTH);
  localparam int unsigned CW         = clog2(CLKS_PER_BIT);
  localparam int unsigned BW         = (clog2(BPM) > 0) ? clog2(BPM) : 1;
  localparam int unsigned TO_LIMIT   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TOW        = (clog2(TO_LIMIT + 1) > 0) ? clog2(TO_LIMIT + 1) : 1;
  localparam int unsigned BIT_END_I  = CLKS_PER_BIT - 1;
  localparam int unsigned HALF_END_I = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned LAST_I     = BPM - 1;
  localparam int unsigned TO_END_I   = (TO_LIMIT > 0) ? TO_LIMIT - 1 : 0;
  localparam logic [CW-1:0]  BIT_END   = BIT_END_I[CW-1:0];
  localparam logic [CW-1:0]  HALF_END  = HALF_END_I[CW-1:0];
  localparam logic [BW-1:0]  LAST_BYTE = LAST_I[BW-1:0];
  localparam logic [TOW-1:0] TO_END    = TO_END_I[TOW-1:0];

  logic                 ready_q;
  logic                 rx_meta, rx_s, rx_prev, rx_fall;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_byte;
  logic [MSG_WIDTH-1:0] pk_word;
  logic [BW-1:0]        pk_cnt;
  logic                 pk_push;
  logic [TOW-1:0]       to_cnt;
  logic                 rx_full, rx_empty, rx_pop;

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;
  logic [BW-1:0]        tx_byte_idx;
  logic [MSG_WIDTH-1:0] tx_sh;
  logic [MSG_WIDTH-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_push, tx_load;

  assign rx_fall           = rx_prev && !rx_s;
  assign RDY_msgOutput_get = !rx_empty;
  assign rx_pop            = EN_msgOutput_get && RDY_msgOutput_get;
  assign RDY_msgInput_put  = ready_q && !tx_full;
  assign tx_push           = EN_msgInput_put && RDY_msgInput_put;

  // A message may be reloaded straight from the last STOP so frames stay contiguous.
  assign tx_load = !tx_empty && ((tx_state == TX_IDLE) ||
                   (tx_state == TX_STOP && tx_cnt == BIT_END && tx_byte_idx == LAST_BYTE));

  serial_msg_fifo #(.WIDTH(MSG_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (sys_clk_pin),
    .rst_n     (sys_rst_pin),
    .push      (pk_push),
    .push_data (pk_word),
    .pop       (rx_pop),
    .pop_data  (msgOutput_get),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  serial_msg_fifo #(.WIDTH(MSG_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (sys_clk_pin),
    .rst_n     (sys_rst_pin),
    .push      (tx_push),
    .push_data (msgInput_put),
    .pop       (tx_load),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) ready_q <= 1'b0;
    else              ready_q <= 1'b1;
  end

  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_byte      <= '0;
      pk_word      <= '0;
      pk_cnt       <= '0;
      pk_push      <= 1'b0;
      to_cnt       <= '0;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      rx_meta      <= rx_pin;
      rx_s         <= rx_meta;
      rx_prev      <= rx_s;
      rx_frame_err <= 1'b0;
      pk_push      <= 1'b0;
      if (pk_push && rx_full && !rx_pop) rx_overflow <= 1'b1;

      // Partial-message timeout only runs while idle, so it never races the STOP update below.
      if (TO_LIMIT != 0 && rx_state == RX_IDLE && pk_cnt != '0 && !rx_fall) begin
        if (to_cnt == TO_END) begin
          to_cnt  <= '0;
          pk_cnt  <= '0;
          pk_word <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_s, rx_byte[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              pk_word[8*pk_cnt +: 8] <= rx_byte;
              if (pk_cnt == LAST_BYTE) begin
                pk_cnt  <= '0;
                pk_push <= 1'b1;
              end else begin
                pk_cnt <= pk_cnt + 1'b1;
              end
            end else begin
              rx_frame_err <= 1'b1;
              pk_cnt       <= '0;
              pk_word      <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte_idx <= '0;
      tx_sh       <= '0;
      tx_pin      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_sh       <= tx_head;
            tx_byte_idx <= '0;
            tx_cnt      <= '0;
            tx_pin      <= 1'b0;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_pin   <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_pin   <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx_pin <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_byte_idx != LAST_BYTE) begin
              tx_byte_idx <= tx_byte_idx + 1'b1;
              tx_pin      <= 1'b0;
              tx_state    <= TX_START;
            end else if (tx_load) begin
              tx_sh       <= tx_head;
              tx_byte_idx <= '0;
              tx_pin      <= 1'b0;
              tx_state    <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
